// File: rtl/slice_height_engine_if.sv
// slice_height_engine_if
//   Request/result bundle for the slice-height engine.
//   Request side : in_valid/in_ready handshake carrying the column tag, both
//                  signed wall-hit distances, their hit flags, cos(beta) and
//                  the fishbowl-correction enable.
//   Result side  : out_valid/out_ready handshake carrying the column tag,
//                  clamped height, chosen side and the no-wall flag.
//   busy         : engine has a request in flight.
//   master = upstream/downstream environment, slave = the engine.
interface slice_height_engine_if #(
  parameter int unsigned DIST_W   = 13,
  parameter int unsigned FRAC_W   = 9,
  parameter int unsigned HEIGHT_W = 7,
  parameter int unsigned COL_W    = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [COL_W-1:0]     in_column;
  logic [DIST_W-1:0]    in_dist_horiz;
  logic [DIST_W-1:0]    in_dist_vert;
  logic                 in_hit_horiz;
  logic                 in_hit_vert;
  logic [FRAC_W:0]      in_cos_beta;
  logic                 fishbowl_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [COL_W-1:0]     out_column;
  logic [HEIGHT_W-1:0]  out_height;
  logic                 out_side;
  logic                 out_no_wall;
  logic                 busy;

  modport master (
    output in_valid, in_column, in_dist_horiz, in_dist_vert,
           in_hit_horiz, in_hit_vert, in_cos_beta, fishbowl_en, out_ready,
    input  in_ready, out_valid, out_column, out_height, out_side,
           out_no_wall, busy
  );

  modport slave (
    input  in_valid, in_column, in_dist_horiz, in_dist_vert,
           in_hit_horiz, in_hit_vert, in_cos_beta, fishbowl_en, out_ready,
    output in_ready, out_valid, out_column, out_height, out_side,
           out_no_wall, busy
  );
endinterface

// File: rtl/slice_height_engine.sv
// slice_height_engine
//   Per-column slice-height engine for the raycast renderer. Picks the nearer
//   of the horizontal/vertical wall hits, optionally applies fishbowl
//   correction (d * cos_beta), divides PROJ_K by the corrected distance with
//   an MSB-first restoring divider and clamps the result to SCREEN_H.
//   Ports:
//     clock : rising-edge system clock
//     reset : synchronous, active-high; aborts any in-flight request
//     bus   : slice_height_engine_if.slave (request and result handshakes)
//   Sequence: IDLE -> SELECT -> CORRECT -> DIVIDE (K_W cycles) -> CLAMP ->
//   DONE -> IDLE. Latency is fixed regardless of data, including no-wall.
module slice_height_engine #(
  parameter int unsigned DIST_W   = 13,
  parameter int unsigned FRAC_W   = 9,
  parameter int unsigned K_W      = 14,
  parameter int unsigned PROJ_K   = 8896,
  parameter int unsigned HEIGHT_W = 7,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned COL_W    = 8
) (
  input logic                 clock,
  input logic                 reset,
  slice_height_engine_if.slave bus
);

  // Corrected distance keeps every bit of (abs * cos) >> FRAC_W.
  localparam int unsigned P_W   = DIST_W + FRAC_W + 1;
  localparam int unsigned D_W   = P_W - FRAC_W;
  localparam int unsigned CNT_W = (K_W > 1) ? $clog2(K_W) : 1;

  localparam logic [DIST_W-1:0] MOST_NEG = {1'b1, {(DIST_W-1){1'b0}}};
  localparam logic [DIST_W-1:0] MOST_POS = {1'b0, {(DIST_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CORRECT,
    S_DIVIDE,
    S_CLAMP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Captured request
  logic [COL_W-1:0]    col_q;
  logic [DIST_W-1:0]   dist_h_q, dist_v_q;
  logic                hit_h_q, hit_v_q;
  logic [FRAC_W:0]     cos_q;
  logic                fb_q;

  // Selection results
  logic [DIST_W-1:0]   sel_abs_q;
  logic                side_q;
  logic                no_wall_q;

  // Divider
  logic [D_W-1:0]      div_q;
  logic [D_W-1:0]      rem_q;
  logic [K_W-1:0]      num_q;
  logic [K_W-1:0]      quo_q;
  logic [CNT_W-1:0]    iter_q;

  // Result registers
  logic [COL_W-1:0]    out_col_q;
  logic [HEIGHT_W-1:0] out_height_q;
  logic                out_side_q;
  logic                out_no_wall_q;

  // Magnitude with the most negative code saturated to the most positive.
  function automatic logic [DIST_W-1:0] sat_abs(input logic [DIST_W-1:0] x);
    if (x == MOST_NEG)
      return MOST_POS;
    else if (x[DIST_W-1])
      return -x;
    else
      return x;
  endfunction

  logic [DIST_W-1:0] abs_h, abs_v;
  logic [D_W-1:0]    corr_d;
  logic [D_W:0]      trial;
  logic              trial_ge;

  assign abs_h    = sat_abs(dist_h_q);
  assign abs_v    = sat_abs(dist_v_q);
  assign corr_d   = D_W'((P_W'(sel_abs_q) * P_W'(cos_q)) >> FRAC_W);
  assign trial    = {rem_q, num_q[K_W-1]};
  assign trial_ge = (trial >= {1'b0, div_q});

  // State register
  always_ff @(posedge clock) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.in_valid) state_d = S_SELECT;
      S_SELECT:  state_d = S_CORRECT;
      S_CORRECT: state_d = S_DIVIDE;
      S_DIVIDE:  if (iter_q == CNT_W'(K_W - 1)) state_d = S_CLAMP;
      S_CLAMP:   state_d = S_DONE;
      S_DONE:    if (bus.out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q         <= '0;
      dist_h_q      <= '0;
      dist_v_q      <= '0;
      hit_h_q       <= 1'b0;
      hit_v_q       <= 1'b0;
      cos_q         <= '0;
      fb_q          <= 1'b0;
      sel_abs_q     <= '0;
      side_q        <= 1'b0;
      no_wall_q     <= 1'b0;
      div_q         <= '0;
      rem_q         <= '0;
      num_q         <= '0;
      quo_q         <= '0;
      iter_q        <= '0;
      out_col_q     <= '0;
      out_height_q  <= '0;
      out_side_q    <= 1'b0;
      out_no_wall_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            col_q    <= bus.in_column;
            dist_h_q <= bus.in_dist_horiz;
            dist_v_q <= bus.in_dist_vert;
            hit_h_q  <= bus.in_hit_horiz;
            hit_v_q  <= bus.in_hit_vert;
            cos_q    <= bus.in_cos_beta;
            fb_q     <= bus.fishbowl_en;
          end
        end
        S_SELECT: begin
          no_wall_q <= !hit_h_q && !hit_v_q;
          // Vertical wins only when strictly nearer; ties stay horizontal.
          if (hit_v_q && (!hit_h_q || (abs_v < abs_h))) begin
            sel_abs_q <= abs_v;
            side_q    <= 1'b1;
          end else begin
            sel_abs_q <= abs_h;
            side_q    <= 1'b0;
          end
        end
        S_CORRECT: begin
          div_q  <= fb_q ? corr_d : D_W'(sel_abs_q);
          rem_q  <= '0;
          num_q  <= K_W'(PROJ_K);
          quo_q  <= '0;
          iter_q <= '0;
        end
        S_DIVIDE: begin
          iter_q <= iter_q + CNT_W'(1);
          if (div_q == '0) begin
            quo_q <= '1;
          end else begin
            rem_q <= trial_ge ? D_W'(trial - {1'b0, div_q}) : trial[D_W-1:0];
            num_q <= {num_q[K_W-2:0], 1'b0};
            quo_q <= {quo_q[K_W-2:0], trial_ge};
          end
        end
        S_CLAMP: begin
          out_col_q     <= col_q;
          out_no_wall_q <= no_wall_q;
          if (no_wall_q) begin
            out_height_q <= '0;
            out_side_q   <= 1'b0;
          end else begin
            out_side_q   <= side_q;
            out_height_q <= (quo_q > K_W'(SCREEN_H)) ? HEIGHT_W'(SCREEN_H)
                                                      : quo_q[HEIGHT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.out_column  = out_col_q;
  assign bus.out_height  = out_height_q;
  assign bus.out_side    = out_side_q;
  assign bus.out_no_wall = out_no_wall_q;

endmodule
